// File: rtl/useq_stack_sequencer.sv
// rtl/useq_stack_sequencer.sv - microsequencer next-address register and subroutine return stack
module useq_stack_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int STACK_LOG2 = 4,
  parameter logic [0:ADDR_WIDTH-1] RESET_ADDR = 12'o0000,
  parameter logic [0:ADDR_WIDTH-1] TRAP_ADDR  = 12'o7777
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic [0:ADDR_WIDTH-1] cromJ,
  input  logic                  cromCALL,
  input  logic                  cromRET,
  input  logic [0:ADDR_WIDTH-1] dispADDR,
  input  logic [0:ADDR_WIDTH-1] skipADDR,
  input  logic                  pageFAIL,
  output logic [0:ADDR_WIDTH-1] addr,
  output logic [0:ADDR_WIDTH-1] dispRET,
  output logic [STACK_LOG2:0]   depth,
  output logic                  stackOVF,
  output logic                  stackUNF
);

  localparam int ENTRIES = 1 << STACK_LOG2;
  localparam logic [STACK_LOG2:0]   DEPTH_FULL = {1'b1, {STACK_LOG2{1'b0}}};
  localparam logic [STACK_LOG2:0]   DEPTH_ONE  = {{STACK_LOG2{1'b0}}, 1'b1};
  localparam logic [STACK_LOG2-1:0] SP_ONE     = {{(STACK_LOG2-1){1'b0}}, 1'b1};

  logic [0:ADDR_WIDTH-1] mem [0:ENTRIES-1];
  logic [STACK_LOG2-1:0] sp;
  logic [STACK_LOG2-1:0] sp_top;
  logic [0:ADDR_WIDTH-1] next;
  logic                  empty;
  logic                  full;
  logic                  do_push;
  logic                  do_replace;
  logic                  do_pop;
  logic                  set_unf;

  assign sp_top  = sp - SP_ONE;
  assign empty   = (depth == '0);
  assign full    = (depth == DEPTH_FULL);
  assign dispRET = empty ? '0 : mem[sp_top];

  always_comb begin
    next       = pageFAIL ? TRAP_ADDR : (cromJ | dispADDR | skipADDR);
    do_push    = 1'b0;
    do_replace = 1'b0;
    do_pop     = 1'b0;
    set_unf    = 1'b0;
    if (pageFAIL) begin
      do_push = 1'b1;
    end else if (cromCALL && cromRET) begin
      // A call+return on an empty stack has no top to replace, so it degrades to a push.
      do_push    = empty;
      do_replace = !empty;
      set_unf    = empty;
    end else if (cromCALL) begin
      do_push = 1'b1;
    end else if (cromRET) begin
      do_pop  = !empty;
      set_unf = empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= RESET_ADDR;
      sp       <= '0;
      depth    <= '0;
      stackOVF <= 1'b0;
      stackUNF <= 1'b0;
    end else if (clken) begin
      addr <= next;
      if (do_push) begin
        sp <= sp + SP_ONE;
        if (full) stackOVF <= 1'b1;
        else      depth    <= depth + DEPTH_ONE;
      end
      if (do_pop) begin
        sp    <= sp_top;
        depth <= depth - DEPTH_ONE;
      end
      if (set_unf) stackUNF <= 1'b1;
    end
  end

  // Frame storage carries no reset; stale entries are masked by depth.
  always_ff @(posedge clk) begin
    if (!rst && clken) begin
      if (do_push)         mem[sp]     <= addr;
      else if (do_replace) mem[sp_top] <= addr;
    end
  end

endmodule

// File: tb/tb_useq_stack_sequencer.sv
// tb/tb_useq_stack_sequencer.sv - randomized and directed checks against a queue-based stack model
module tb_useq_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst, clken, cromCALL, cromRET, pageFAIL;
  logic [0:11] cromJ, dispADDR, skipADDR;
  logic [0:11] addr, dispRET;
  logic [4:0]  depth;
  logic        stackOVF, stackUNF;

  int errors = 0;
  int checks = 0;

  logic [11:0] m_addr;
  logic [11:0] q[$];
  logic        m_ovf, m_unf;
  logic [11:0] saved;

  always #5 clk = ~clk;

  useq_stack_sequencer dut (
    .clk(clk), .rst(rst), .clken(clken), .cromJ(cromJ), .cromCALL(cromCALL),
    .cromRET(cromRET), .dispADDR(dispADDR), .skipADDR(skipADDR), .pageFAIL(pageFAIL),
    .addr(addr), .dispRET(dispRET), .depth(depth), .stackOVF(stackOVF), .stackUNF(stackUNF)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] m_ret();
    return (q.size() != 0) ? q[q.size()-1] : 12'o0;
  endfunction

  task automatic m_push(input logic [11:0] a);
    if (q.size() == 16) begin
      void'(q.pop_front());
      m_ovf = 1'b1;
    end
    q.push_back(a);
  endtask

  task automatic model_edge();
    logic [11:0] nxt;
    if (rst) begin
      m_addr = 12'o0000;
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (clken) begin
      nxt = pageFAIL ? 12'o7777 : (cromJ | dispADDR | skipADDR);
      if (pageFAIL) m_push(m_addr);
      else if (cromCALL && cromRET) begin
        if (q.size() == 0) begin
          m_push(m_addr);
          m_unf = 1'b1;
        end else q[q.size()-1] = m_addr;
      end else if (cromCALL) m_push(m_addr);
      else if (cromRET) begin
        if (q.size() != 0) void'(q.pop_back());
        else m_unf = 1'b1;
      end
      m_addr = nxt;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("addr", addr, m_addr);
    check("dispRET", dispRET, m_ret());
    check("depth", depth, q.size());
    check("stackOVF", stackOVF, m_ovf);
    check("stackUNF", stackUNF, m_unf);
  endtask

  task automatic idle();
    rst = 0; clken = 1; cromCALL = 0; cromRET = 0; pageFAIL = 0;
    cromJ = '0; dispADDR = '0; skipADDR = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    m_addr = '0; m_ovf = 0; m_unf = 0;
    idle();
    rst = 1; step();
    check("t1_reset_addr", addr, 12'o0000);
    check("t1_reset_depth", depth, 0);

    idle(); cromJ = 12'o0100; step();
    check("t1_jump", addr, 12'o0100);

    cromJ = 12'o0200; dispADDR = 12'o0017; skipADDR = 12'o0001; step();
    check("t2_or_merge", addr, 12'o0217);

    idle(); cromJ = 12'o0300; step();
    cromCALL = 1; cromJ = 12'o1000; step();
    check("t3_call_depth", depth, 1);
    check("t3_call_ret", dispRET, 12'o0300);
    idle(); cromRET = 1; cromJ = 12'o0001; dispADDR = m_ret(); step();
    check("t3_return_addr", addr, 12'o0301);
    check("t3_return_depth", depth, 0);

    idle(); cromJ = 12'o0450; step();
    pageFAIL = 1; cromCALL = 1; cromJ = 12'o0123; dispADDR = 12'o0055; step();
    check("t4_trap_addr", addr, 12'o7777);
    check("t4_trap_depth", depth, 1);
    check("t4_trap_ret", dispRET, 12'o0450);

    do_reset();
    cromJ = 12'd1; step();
    for (int i = 1; i <= 17; i++) begin
      idle(); cromCALL = 1; cromJ = 12'(i + 1); step();
    end
    check("t5_full_depth", depth, 16);
    check("t5_ovf", stackOVF, 1);
    for (int k = 0; k < 16; k++) begin
      check("t5_pop_value", dispRET, 17 - k);
      idle(); cromRET = 1; step();
    end
    idle(); cromRET = 1; step();
    check("t5_unf", stackUNF, 1);
    check("t5_unf_ret", dispRET, 0);
    check("t5_unf_depth", depth, 0);

    do_reset();
    cromJ = 12'o0111; step();
    cromCALL = 1; cromJ = 12'o0222; step();
    cromJ = 12'o0500; step();
    for (int i = 0; i < 5; i++) begin
      clken = 0; cromCALL = 1'($urandom); cromRET = 1'($urandom); pageFAIL = 1'($urandom);
      cromJ = 12'($urandom); dispADDR = 12'($urandom); skipADDR = 12'($urandom);
      step();
      check("t6_stall_addr", addr, 12'o0500);
      check("t6_stall_depth", depth, 2);
    end
    idle(); cromCALL = 1; cromRET = 1; cromJ = 12'o0600; step();
    check("t6_callret_depth", depth, 2);
    check("t6_callret_ret", dispRET, 12'o0500);
    idle(); cromRET = 1; step();
    check("t6_lower_entry", dispRET, 12'o0111);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      clken    = ($urandom_range(0, 9) < 8);
      pageFAIL = ($urandom_range(0, 19) == 0);
      cromCALL = ($urandom_range(0, 3) == 0);
      cromRET  = ($urandom_range(0, 3) == 0);
      cromJ    = 12'($urandom);
      dispADDR = ($urandom_range(0, 1) == 0) ? 12'o0 : 12'($urandom);
      skipADDR = {11'b0, 1'($urandom)};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/useq_stack_sequencer.md
# useq_stack_sequencer

Microsequencer next-address controller and subroutine return stack for the KS-10 CPU control store. Each enabled cycle it registers the next control-ROM address, formed from the microword jump field, the skip logic and the N-way dispatch address. It also maintains the microcode call stack whose top entry drives the return-dispatch (`dispRET`) input of the dispatch logic. Page-fail traps are injected here as a forced call to a fixed trap address.

## Interface

Parameters:
- `ADDR_WIDTH`, 12: control-ROM address width; bit 0 is the MSB.
- `STACK_LOG2`, 4: log2 of the stack depth. The default gives 16 entries.
- `RESET_ADDR`, 12'o0000: microaddress loaded at reset.
- `TRAP_ADDR`, 12'o7777: microaddress forced on a page-fail trap.

Ports:
- `clk`, in, 1: CPU clock.
- `rst`, in, 1: synchronous, active-high reset.
- `clken`, in, 1: microcycle enable. When low, all state holds.
- `cromJ`, in, [0:11]: jump field of the current microword.
- `cromCALL`, in, 1: current microword is a subroutine call.
- `cromRET`, in, 1: current microword returns; pops the stack.
- `dispADDR`, in, [0:11]: dispatch address from the dispatch logic. It is all zeros when no dispatch is selected.
- `skipADDR`, in, [0:11]: skip contribution; only bit 11 is normally set.
- `pageFAIL`, in, 1: page-fail trap request, sampled when `clken` is high.
- `addr`, out, [0:11]: registered current control-ROM address.
- `dispRET`, out, [0:11]: top-of-stack entry. It is 0 when the stack is empty.
- `depth`, out, [STACK_LOG2:0]: number of valid stack entries.
- `stackOVF`, out, 1: sticky overflow flag.
- `stackUNF`, out, 1: sticky underflow flag.

## Operation

Next address:
- Normal cycle: `next = cromJ | dispADDR | skipADDR`. This is a bitwise OR; dispatch and skip can only set bits, never clear them.
- Trap cycle (`pageFAIL`=1): `next = TRAP_ADDR`. `cromJ`, `dispADDR` and `skipADDR` are ignored.

Stack storage and `dispRET`:
- The stack is a circular RAM/register file of 2^STACK_LOG2 entries, each ADDR_WIDTH wide.
- It has a write pointer `sp`, and `depth` saturates at 2^STACK_LOG2.
- `dispRET` is combinational: `mem[sp-1]` when `depth` is nonzero, else 0.

Stack operations, evaluated only when `clken`=1. Priority is top to bottom:
1. `pageFAIL`: push the current `addr`, so that a return re-executes the faulting microinstruction. `cromCALL` and `cromRET` are ignored.
2. `cromCALL` and `cromRET` together: replace the top entry with `addr`. `depth` is unchanged. If `depth`=0, this acts as a push and sets `stackUNF`.
3. `cromCALL` alone: push `addr`.
4. `cromRET` alone: pop.
5. Neither: no stack change.

Push:
- `mem[sp] <= addr`, then `sp <= sp+1` (modulo the depth).
- If `depth` is already full, `depth` stays full, the oldest entry is overwritten, and `stackOVF` is set.

Pop:
- If `depth` is greater than 0: `sp <= sp-1`, `depth <= depth-1`.
- If `depth` is 0: no pointer change, and `stackUNF` is set.
- The value popped is the one presented on `dispRET` during the same cycle. The return target therefore flows through `dispADDR` into `next` in that cycle.

Flags:
- `stackOVF` and `stackUNF` are sticky. They are cleared only by `rst`.

## Timing

Reset (`rst`=1 at a rising edge of `clk`):
- Reset takes priority over `clken`.
- After the edge: `addr`=RESET_ADDR, `sp`=0, `depth`=0, `stackOVF`=0, `stackUNF`=0, `dispRET`=0.
- Stack RAM contents are don't-care.
- A reset in the middle of a call chain discards all frames.

Enabled cycles:
- Updates occur on the rising edge of `clk` when `clken`=1.
- `addr` presents `next` one cycle after its inputs were applied.
- `dispRET` changes in the same cycle as the push or pop that caused it, i.e. it reflects the new top as soon as the edge completes.

Held cycles:
- With `clken`=0, `addr`, the stack, `depth` and both flags hold indefinitely.
- `pageFAIL` is not latched while `clken`=0; the requester must hold it until an enabled cycle.

Combinational paths:
- The only combinational path from inputs to outputs is none: `dispRET` depends only on state.
- The `dispRET` → dispatch → `dispADDR` loop is therefore not a combinational loop.

## Test plan

1. **Reset and straight-line jump.**
   - Stimulus: assert `rst`, then release. With `clken`=1 and `cromJ`=12'o0100, apply zero `dispADDR` and `skipADDR`.
   - Required: `addr` is 0 after reset and 12'o0100 one cycle later. `depth`=0, both flags 0.

2. **OR merge.**
   - Stimulus: `cromJ`=12'o0200, `dispADDR`=12'o0017, `skipADDR`=12'o0001.
   - Required: `addr`=12'o0217.

3. **Call/return round trip.**
   - Stimulus: at `addr`=12'o0300, issue `cromCALL` with `cromJ`=12'o1000. Then at 12'o1000 issue `cromRET` with `cromJ`=12'o0001 and `dispADDR`=`dispRET`.
   - Required: `depth`=1 and `dispRET`=12'o0300 after the call. After the return, `addr`=12'o0301 and `depth`=0.

4. **Page-fail trap.**
   - Stimulus: at `addr`=12'o0450, assert `pageFAIL` together with `cromCALL`.
   - Required: `addr`=12'o7777, `depth`=1, `dispRET`=12'o0450. Only one entry is pushed.

5. **Overflow and underflow.**
   - Overflow stimulus: 17 consecutive calls from addresses 1..17.
   - Overflow required: `depth`=16, `stackOVF`=1, and 16 pops return 17 down to 2.
   - Underflow stimulus: one more pop.
   - Underflow required: `stackUNF`=1, `dispRET`=0, `depth`=0.

6. **Stall and simultaneous call/return.**
   - Stall stimulus: hold `clken`=0 for 5 cycles while toggling all inputs.
   - Stall required: no state change.
   - Simultaneous stimulus: with `depth`=2, at `addr`=12'o0500 issue `cromCALL` and `cromRET` together.
   - Simultaneous required: `depth`=2, `dispRET`=12'o0500, and the lower entry is unchanged.
